branch_exec_unit: RTL and testbench
===================================

Name: branch_exec_unit

Overview:
- Execution stage directly downstream of the branch reservation station.
- Takes one ready branch/jump per cycle (op, two operands, imm, pc, destination ROB tag).
- Resolves taken/not-taken, target address and link value, then queues the result in a small output FIFO.
- FIFO entries are broadcast on the branch CDB slot under an arbiter grant, with backpressure returned to the RS.

Parameters:
- DATA_W, 32, operand / data / address width
- TAG_W, 4, ROB tag width
- OP_W, 6, op code width
- DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  ROB misprediction clear; synchronous, takes priority over everything except reset
- in_valid  in  1  issue strobe from the branch RS
- in_op  in  OP_W  op code
- in_reg1  in  DATA_W  rs1 value
- in_reg2  in  DATA_W  rs2 value
- in_imm  in  DATA_W  sign-extended immediate
- in_pc  in  DATA_W  instruction pc
- in_tag  in  TAG_W  destination ROB tag
- busy_full  out  1  tells the RS to stop issuing
- cdb_valid  out  1  head result valid
- cdb_tag  out  TAG_W  head ROB tag
- cdb_data  out  DATA_W  link value: pc+4 for JAL/JALR, 0 otherwise
- cdb_taken  out  1  resolved direction
- cdb_target  out  DATA_W  resolved next pc
- cdb_grant  in  1  arbiter accepts head this cycle
- overflow_err  out  1  sticky: an issue arrived while the FIFO was full

Behaviour:
- Op codes: JAL=1, JALR=2, BEQ=3, BNE=4, BLT=5, BGE=6, BLTU=7, BGEU=8.
  - Any other code: taken=0, target=pc+4, data=0.
- Resolution, combinational on the inputs:
  - BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - Taken branch: target = pc+imm.
  - Not-taken branch: target = pc+4.
  - JAL: taken=1, target = pc+imm.
  - JALR: taken=1, target = (reg1+imm) & ~1.
  - All sums are modulo 2^DATA_W; no carry out.
- Push: on the rising edge where rdy=1, flush=0, in_valid=1 and the FIFO is not full, the resolved entry is written at the tail.
  - Latency: issue in cycle N is visible at the head (cdb_valid=1) in cycle N+1 at the earliest.
- Head outputs are driven from the head entry; when empty, cdb_valid=0 and all cdb_* fields=0.
- Pop: on an edge with rdy=1, cdb_valid=1 and cdb_grant=1.
  - cdb_grant while empty is ignored.
  - Head is held stable while cdb_grant=0.
- Simultaneous push and pop:
  - Count is unchanged; pointers both advance.
  - Allowed at count=DEPTH: the pop frees the slot for the push.
  - At count=0 the push lands; cdb_valid rises next cycle (no bypass).
- busy_full = (count >= DEPTH-1), combinational from count.
  - The one slot of slack absorbs the RS's registered issue.
- Issue with count=DEPTH and no pop in that cycle: the entry is dropped and overflow_err is set.
  - overflow_err clears only on reset.
- flush=1 (rdy=1): count=0, head and tail pointers=0; same-cycle issue and grant are ignored. overflow_err is not cleared.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Reset (async, any time, including mid-queue): count, pointers, overflow_err=0.
  - All cdb_* = 0 and busy_full=0 immediately while rst_n=0.
- rdy=0: no push, no pop, no flush effect; outputs hold.

Test Plan:
- BEQ reg1=reg2=5, pc=0x100, imm=0x20, tag=3 -> next cycle cdb_valid=1, tag=3, taken=1, target=0x120, data=0.
- BLT reg1=0xFFFFFFFF, reg2=1 -> taken=1. BLTU with the same operands -> taken=0, target=pc+4.
- JALR reg1=0x1003, imm=0x10, pc=0x200 -> taken=1, target=0x1012, data=0x204.
- Grant held at 0 while issuing 4 ops:
  - busy_full=1 once count=3.
  - 5th issue -> dropped, overflow_err=1.
  - Then pulse grant 4 times -> results pop in issue order, then cdb_valid=0.
- Queue 2 entries, assert flush together with in_valid -> next cycle cdb_valid=0, count=0, issued op absent.
- Queue 3 entries, drop rst_n mid-cycle -> cdb_valid=0 and busy_full=0 before the next edge; after release the FIFO is empty.

Source files
------------

// File: rtl/branch_exec_unit.sv
// branch_exec_unit
//   Branch/jump execution stage. Resolves one issued branch per cycle
//   (direction, next pc, link value) and queues the result in a small FIFO
//   that drains onto the branch CDB slot under an arbiter grant.
//
// Ports:
//   clk, rst_n          system clock (rising edge), async active-low reset
//   rdy                 global enable; all state holds while low
//   flush               synchronous queue clear (ignores same-cycle issue/grant)
//   in_valid, in_op, in_reg1, in_reg2, in_imm, in_pc, in_tag
//                       issue interface from the branch reservation station
//   busy_full           stop-issue indication back to the RS
//   cdb_valid, cdb_tag, cdb_data, cdb_taken, cdb_target
//                       head-of-queue result (all zero when empty)
//   cdb_grant           arbiter accepts the head this cycle
//   overflow_err        sticky: an issue arrived with the queue full
module branch_exec_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_reg1,
    input  logic [DATA_W-1:0] in_reg2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              busy_full,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_taken,
    output logic [DATA_W-1:0] cdb_target,
    input  logic              cdb_grant,
    output logic              overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_JALR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(8);

    // ---------------- resolution ----------------
    logic [DATA_W-1:0] pc_imm, pc_plus4, jalr_sum;
    logic              is_branch;
    logic              res_taken;
    logic [DATA_W-1:0] res_target, res_data;

    assign pc_imm   = in_pc + in_imm;
    assign pc_plus4 = in_pc + DATA_W'(4);
    assign jalr_sum = in_reg1 + in_imm;

    always_comb begin
        is_branch  = 1'b0;
        res_taken  = 1'b0;
        res_target = pc_plus4;
        res_data   = '0;
        case (in_op)
            OP_JAL: begin
                res_taken  = 1'b1;
                res_target = pc_imm;
                res_data   = pc_plus4;
            end
            OP_JALR: begin
                res_taken  = 1'b1;
                res_target = {jalr_sum[DATA_W-1:1], 1'b0};
                res_data   = pc_plus4;
            end
            OP_BEQ:  begin is_branch = 1'b1; res_taken = (in_reg1 == in_reg2); end
            OP_BNE:  begin is_branch = 1'b1; res_taken = (in_reg1 != in_reg2); end
            OP_BLT:  begin is_branch = 1'b1; res_taken = ($signed(in_reg1) <  $signed(in_reg2)); end
            OP_BGE:  begin is_branch = 1'b1; res_taken = ($signed(in_reg1) >= $signed(in_reg2)); end
            OP_BLTU: begin is_branch = 1'b1; res_taken = (in_reg1 <  in_reg2); end
            OP_BGEU: begin is_branch = 1'b1; res_taken = (in_reg1 >= in_reg2); end
            default: ;
        endcase
        if (is_branch && res_taken) begin
            res_target = pc_imm;
        end
    end

    // ---------------- result FIFO ----------------
    logic [TAG_W-1:0]  tag_mem    [DEPTH];
    logic [DATA_W-1:0] data_mem   [DEPTH];
    logic              taken_mem  [DEPTH];
    logic [DATA_W-1:0] target_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, full, active, push, pop, drop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign active = rdy & ~flush;
    assign pop    = active & ~empty & cdb_grant;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push   = active & in_valid & (~full | pop);
    assign drop   = active & in_valid & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                if (drop) overflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]    <= in_tag;
            data_mem[wr_ptr]   <= res_data;
            taken_mem[wr_ptr]  <= res_taken;
            target_mem[wr_ptr] <= res_target;
        end
    end

    // Slack of one slot covers the issue already in flight from the RS.
    assign busy_full  = (count >= CNT_W'(DEPTH - 1));
    assign cdb_valid  = ~empty;
    assign cdb_tag    = empty ? '0 : tag_mem[rd_ptr];
    assign cdb_data   = empty ? '0 : data_mem[rd_ptr];
    assign cdb_taken  = empty ? 1'b0 : taken_mem[rd_ptr];
    assign cdb_target = empty ? '0 : target_mem[rd_ptr];

endmodule

// File: tb/tb_branch_exec_unit.sv
module tb_branch_exec_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush, in_valid, cdb_grant;
    logic [5:0]  in_op;
    logic [31:0] in_reg1, in_reg2, in_imm, in_pc;
    logic [3:0]  in_tag;
    logic        busy_full, cdb_valid, cdb_taken, overflow_err;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data, cdb_target;

    int checks = 0;
    int errors = 0;

    branch_exec_unit #(.DATA_W(32), .TAG_W(4), .OP_W(6), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
        .busy_full(busy_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .cdb_grant(cdb_grant), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t q[$];
    logic m_ovf = 1'b0;

    function automatic ent_t resolve(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                                     input logic [3:0] tag);
        ent_t e;
        logic cond;
        e.tag = tag; e.data = 0; e.taken = 0; e.target = pc + 32'd4;
        cond = 0;
        case (op)
            6'd1: begin e.taken = 1; e.target = pc + imm; e.data = pc + 32'd4; end
            6'd2: begin e.taken = 1; e.target = (a + imm) & 32'hFFFF_FFFE; e.data = pc + 32'd4; end
            6'd3: cond = (a == b);
            6'd4: cond = (a != b);
            6'd5: cond = ($signed(a) < $signed(b));
            6'd6: cond = !($signed(a) < $signed(b));
            6'd7: cond = (a < b);
            6'd8: cond = !(a < b);
            default: ;
        endcase
        if (op >= 3 && op <= 8) begin
            e.taken = cond;
            if (cond) e.target = pc + imm;
        end
        return e;
    endfunction

    // Applies one rising edge to the model using the inputs held across it.
    task automatic model_step();
        bit do_pop;
        if (!rst_n) begin
            q.delete();
            m_ovf = 0;
        end else if (rdy) begin
            if (flush) begin
                q.delete();
            end else begin
                do_pop = (q.size() > 0) && cdb_grant;
                if (do_pop) void'(q.pop_front());
                if (in_valid) begin
                    if (q.size() < DEPTH)
                        q.push_back(resolve(in_op, in_reg1, in_reg2, in_imm, in_pc, in_tag));
                    else
                        m_ovf = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    ent_t exp_h;
    always @(negedge clk) begin
        exp_h = (q.size() > 0) ? q[0] : '0;
        chk("cdb_valid",    {31'd0, cdb_valid},    {31'd0, q.size() > 0});
        chk("cdb_tag",      {28'd0, cdb_tag},      {28'd0, exp_h.tag});
        chk("cdb_data",     cdb_data,              exp_h.data);
        chk("cdb_taken",    {31'd0, cdb_taken},    {31'd0, exp_h.taken});
        chk("cdb_target",   cdb_target,            exp_h.target);
        chk("busy_full",    {31'd0, busy_full},    {31'd0, q.size() >= DEPTH - 1});
        chk("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic v, input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                         input logic [3:0] tag, input logic g, fl, rd);
        in_valid = v; in_op = op; in_reg1 = a; in_reg2 = b; in_imm = imm; in_pc = pc;
        in_tag = tag; cdb_grant = g; flush = fl; rdy = rd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic g);
        cycle(0, 0, 0, 0, 0, 0, 0, g, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; rdy = 1; flush = 0; in_valid = 0; cdb_grant = 0;
        in_op = 0; in_reg1 = 0; in_reg2 = 0; in_imm = 0; in_pc = 0; in_tag = 0;
        #12;
        chk("reset_valid", {31'd0, cdb_valid}, 0);
        chk("reset_busy",  {31'd0, busy_full}, 0);
        chk("reset_ovf",   {31'd0, overflow_err}, 0);
        @(posedge clk); model_step(); #1;
        rst_n = 1;
        idle(0);

        // BEQ taken
        cycle(1, 3, 5, 5, 32'h20, 32'h100, 3, 0, 0, 1);
        @(negedge clk);
        chk("beq_valid",  {31'd0, cdb_valid}, 1);
        chk("beq_tag",    {28'd0, cdb_tag}, 3);
        chk("beq_taken",  {31'd0, cdb_taken}, 1);
        chk("beq_target", cdb_target, 32'h120);
        chk("beq_data",   cdb_data, 0);
        idle(1);
        @(negedge clk);
        chk("beq_popped", {31'd0, cdb_valid}, 0);

        // BLT signed taken, then BLTU same operands not taken (pushed during pop)
        cycle(1, 5, 32'hFFFF_FFFF, 1, 32'h40, 32'h300, 5, 0, 0, 1);
        @(negedge clk);
        chk("blt_taken",  {31'd0, cdb_taken}, 1);
        chk("blt_target", cdb_target, 32'h340);
        cycle(1, 7, 32'hFFFF_FFFF, 1, 32'h40, 32'h300, 6, 1, 0, 1);
        @(negedge clk);
        chk("bltu_tag",    {28'd0, cdb_tag}, 6);
        chk("bltu_taken",  {31'd0, cdb_taken}, 0);
        chk("bltu_target", cdb_target, 32'h304);
        idle(1);

        // JALR
        cycle(1, 2, 32'h1003, 0, 32'h10, 32'h200, 7, 0, 0, 1);
        @(negedge clk);
        chk("jalr_taken",  {31'd0, cdb_taken}, 1);
        chk("jalr_target", cdb_target, 32'h1012);
        chk("jalr_data",   cdb_data, 32'h204);
        idle(1);

        // fill with grant held low, overflow on the 5th issue
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0, 32'(i * 4), 32'h400, 4'(i + 1), 0, 0, 1);
            @(negedge clk);
            chk("fill_busy", {31'd0, busy_full}, (i >= 2) ? 1 : 0);
        end
        cycle(1, 1, 0, 0, 0, 32'h400, 9, 0, 0, 1);
        @(negedge clk);
        chk("ovf_set",  {31'd0, overflow_err}, 1);
        chk("ovf_head", {28'd0, cdb_tag}, 1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", {28'd0, cdb_tag}, 32'(i + 1));
            idle(1);
            @(negedge clk);
        end
        chk("drain_empty", {31'd0, cdb_valid}, 0);

        // flush with same-cycle issue and grant
        cycle(1, 3, 1, 1, 8, 32'h600, 10, 0, 0, 1);
        cycle(1, 3, 1, 1, 8, 32'h600, 11, 0, 0, 1);
        cycle(1, 3, 1, 1, 8, 32'h600, 12, 1, 1, 1);
        @(negedge clk);
        chk("flush_valid", {31'd0, cdb_valid}, 0);
        chk("flush_ovf",   {31'd0, overflow_err}, 1);
        idle(0);
        @(negedge clk);
        chk("flush_absent", {31'd0, cdb_valid}, 0);

        // rdy low freezes everything, including flush
        cycle(1, 4, 1, 2, 8, 32'h700, 13, 0, 0, 1);
        cycle(1, 4, 1, 2, 8, 32'h700, 14, 1, 1, 0);
        @(negedge clk);
        chk("rdy_hold_tag", {28'd0, cdb_tag}, 13);
        idle(1);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 31) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            cycle($urandom_range(0, 9) < 6, 6'($urandom_range(0, 10)), a, b, $urandom,
                  $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 9) != 0);
        end

        // async reset mid-queue
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 4, 32'h800, 4'(i), 0, 0, 1);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy_full}, 1);
        @(posedge clk); model_step(); #3;
        rst_n = 0;
        q.delete(); m_ovf = 0;
        #1;
        chk("rst_valid", {31'd0, cdb_valid}, 0);
        chk("rst_busy",  {31'd0, busy_full}, 0);
        chk("rst_ovf",   {31'd0, overflow_err}, 0);
        @(posedge clk); model_step(); #1;
        rst_n = 1;
        idle(0);
        @(negedge clk);
        chk("post_rst_empty", {31'd0, cdb_valid}, 0);
        cycle(1, 4, 1, 2, 8, 32'h500, 2, 0, 0, 1);
        @(negedge clk);
        chk("post_rst_target", cdb_target, 32'h508);
        idle(1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
